// File: rtl/sub16bit_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : sub16bit_serial_if
// Description : Handshake and operand/result bundle for the bit-serial
//               subtractor. The master issues start/A/B/Bin and collects
//               busy/done/Y/Bout/Ov; the slave is the subtractor itself.
//   start  : request, honoured only while busy is low
//   A, B   : minuend and subtrahend (LENGTH bits)
//   Bin    : borrow-in
//   busy   : operation in progress
//   done   : one-cycle pulse, results valid
//   Y      : difference modulo 2^LENGTH
//   Bout   : unsigned borrow-out
//   Ov     : signed overflow
// Revision    : 1.0 - initial release
// ============================================================================
interface sub16bit_serial_if #(
    parameter int LENGTH = 16
);
    logic              start;
    logic [LENGTH-1:0] A;
    logic [LENGTH-1:0] B;
    logic              Bin;
    logic              busy;
    logic              done;
    logic [LENGTH-1:0] Y;
    logic              Bout;
    logic              Ov;

    modport master (
        output start, A, B, Bin,
        input  busy, done, Y, Bout, Ov
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, Y, Bout, Ov
    );
endinterface
`default_nettype wire

// File: rtl/sub16bit_serial.sv
`default_nettype none
// ============================================================================
// Module      : sub16bit_serial
// Description : Bit-serial subtractor computing Y = A - B - Bin, LSB first,
//               one bit per clock through a single full-subtractor cell.
//               A start/busy/done handshake frames each operation; results
//               hold until the next completion or reset.
// Ports       :
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : slave side of sub16bit_serial_if (start, A, B, Bin in;
//            busy, done, Y, Bout, Ov out)
// Revision    : 1.0 - initial release
// ============================================================================
module sub16bit_serial #(
    parameter int LENGTH = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    sub16bit_serial_if.slave   bus
);

    localparam int CNT_W = (LENGTH > 2) ? $clog2(LENGTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(LENGTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [LENGTH-1:0] a_q,     a_d;
    logic [LENGTH-1:0] b_q,     b_d;
    logic              br_q,    br_d;
    // Holds the LENGTH-1 difference bits already produced; the final bit
    // is merged in combinationally on the completing edge.
    logic [LENGTH-2:0] res_q,   res_d;
    logic [LENGTH-1:0] y_q,     y_d;
    logic              bout_q,  bout_d;
    logic              ov_q,    ov_d;
    logic              done_q,  done_d;

    // Full-subtractor cell on the current LSBs of the operand shifters.
    logic              w_diff;
    logic              w_borrow;
    logic [LENGTH-1:0] w_cat;

    assign w_diff   = a_q[0] ^ b_q[0] ^ br_q;
    assign w_borrow = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign w_cat    = {w_diff, res_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        res_d   = res_q;
        y_d     = y_q;
        bout_d  = bout_q;
        ov_d    = ov_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    br_d    = bus.Bin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = w_borrow;
                res_d = w_cat[LENGTH-1:1];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_LAST_BIT) begin
                    // a_q[0]/b_q[0] now hold the operand sign bits and
                    // w_diff is the result sign bit.
                    y_d     = w_cat;
                    bout_d  = w_borrow;
                    ov_d    = (a_q[0] ^ b_q[0]) & (w_diff ^ a_q[0]);
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            y_q     <= '0;
            bout_q  <= 1'b0;
            ov_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            res_q   <= res_d;
            y_q     <= y_d;
            bout_q  <= bout_d;
            ov_q    <= ov_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = done_q;
    assign bus.Y    = y_q;
    assign bus.Bout = bout_q;
    assign bus.Ov   = ov_q;

endmodule
`default_nettype wire
